// File: rtl/lm_event_queue_pkg.sv
// ---------------------------------------------------------------------------
// lm_event_queue_pkg
// Shared LM parameters for the LED event queue and its storage.
//   WIDTH_LEDS : width of one LED pattern entry
//   LM_DEPTH   : default number of queued patterns
//   LM_DWELL   : default number of clock cycles each pattern is shown
//   lm_state_e : pacing FSM states (IDLE = nothing to show, SHOW = head shown)
// ---------------------------------------------------------------------------
package lm_event_queue_pkg;

  localparam int          WIDTH_LEDS = 8;
  localparam int          LM_DEPTH   = 8;
  localparam int unsigned LM_DWELL   = 25_000_000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } lm_state_e;

endpackage

// File: rtl/lm_fifo_mem.sv
// ---------------------------------------------------------------------------
// lm_fifo_mem
// DEPTH x WIDTH register array backing the LED event queue.
// One synchronous write port, one asynchronous read port.
//   clk      : write clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : data to store
//   rd_addr  : read address
//   rd_data  : combinational read of mem[rd_addr]
// ---------------------------------------------------------------------------
module lm_fifo_mem
  import lm_event_queue_pkg::*;
#(
  parameter int WIDTH = WIDTH_LEDS,
  parameter int DEPTH = LM_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The array is not reset: the queue logic never exposes an entry that
  // has not been written since the last reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lm_event_queue.sv
// ---------------------------------------------------------------------------
// lm_event_queue
// Three-source LED pattern queue with paced read-out. Error, data and
// actualization sources offer patterns with valid/ready handshakes; at most
// one is accepted per cycle (err > dat > act). The head entry is presented
// on rd_data for DWELL cycles and then popped.
//   clk, rst_n            : clock, asynchronous active-low reset
//   err_valid / err_data  : error pattern offer
//   dat_valid / dat_data  : data pattern offer
//   act_valid / act_data  : actualization pattern offer
//   err_ready / dat_ready / act_ready : offer accepted this cycle
//   rd_data               : head entry (0 when empty)
//   fifo_empty            : queue holds no entries
//   count                 : current occupancy
// ---------------------------------------------------------------------------
module lm_event_queue
  import lm_event_queue_pkg::*;
#(
  parameter int          WIDTH = WIDTH_LEDS,
  parameter int          DEPTH = LM_DEPTH,
  parameter int unsigned DWELL = LM_DWELL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   err_valid,
  input  logic [WIDTH-1:0]       err_data,
  input  logic                   dat_valid,
  input  logic [WIDTH-1:0]       dat_data,
  input  logic                   act_valid,
  input  logic [WIDTH-1:0]       act_data,
  output logic                   err_ready,
  output logic                   dat_ready,
  output logic                   act_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   fifo_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = AW + 1;
  localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);

  lm_state_e        state;
  logic [31:0]      dwell_cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             pop;
  logic             full;
  logic             can_push;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] mem_rd;

  // The pop decision comes from registered state only, so a full queue can
  // still accept in the same cycle it releases its head without any path
  // from the data inputs to the readies. Readies are held low in reset.
  assign pop      = (state == ST_SHOW) && (dwell_cnt == DWELL_LAST);
  assign full     = (count_q == CW'(DEPTH));
  assign can_push = rst_n && (!full || pop);

  // Fixed-priority grant: only the winning source sees ready.
  always_comb begin
    err_ready = can_push && err_valid;
    dat_ready = can_push && dat_valid && !err_valid;
    act_ready = can_push && act_valid && !err_valid && !dat_valid;
  end

  assign push = err_ready || dat_ready || act_ready;

  always_comb begin
    push_data = act_data;
    if (err_valid) begin
      push_data = err_data;
    end else if (dat_valid) begin
      push_data = dat_data;
    end
  end

  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + CW'(1);
    end else if (pop && !push) begin
      count_next = count_q - CW'(1);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_next;
    end
  end

  // Pacing FSM. A push while IDLE only starts the display; it cannot be
  // popped in the same cycle. After each pop the counter restarts so the
  // next head gets a full dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dwell_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          dwell_cnt <= '0;
          if (push) begin
            state <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (pop) begin
            dwell_cnt <= '0;
            if (count_next == '0) begin
              state <= ST_IDLE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 32'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          dwell_cnt <= '0;
        end
      endcase
    end
  end

  lm_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (push_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  assign fifo_empty = (count_q == '0);
  assign rd_data    = fifo_empty ? '0 : mem_rd;
  assign count      = count_q;

endmodule

// File: tb/tb_lm_event_queue.sv
// ---------------------------------------------------------------------------
// tb_lm_event_queue
// Three queue instances with different depth/dwell settings, each driven by
// randomized held offers and compared every cycle against a list-based
// model: the head is shown for DWELL cycles, then removed; grants go to the
// highest-priority valid source whenever there is room.
// ---------------------------------------------------------------------------
module tb_lm_event_queue;

  localparam int NI = 3;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [NI];
  logic       ev [NI];
  logic       dv [NI];
  logic       av [NI];
  logic [7:0] ed [NI];
  logic [7:0] dd [NI];
  logic [7:0] ad [NI];
  logic       er [NI];
  logic       dr [NI];
  logic       ar [NI];
  logic       emp [NI];
  logic [7:0] rd [NI];
  logic [3:0] cnt0;
  logic [2:0] cnt1;
  logic [3:0] cnt2;
  logic [3:0] cnt_w [NI];

  always_comb begin
    cnt_w[0] = cnt0;
    cnt_w[1] = {1'b0, cnt1};
    cnt_w[2] = cnt2;
  end

  lm_event_queue #(.WIDTH(8), .DEPTH(8), .DWELL(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .err_valid(ev[0]), .err_data(ed[0]),
    .dat_valid(dv[0]), .dat_data(dd[0]),
    .act_valid(av[0]), .act_data(ad[0]),
    .err_ready(er[0]), .dat_ready(dr[0]), .act_ready(ar[0]),
    .rd_data(rd[0]), .fifo_empty(emp[0]), .count(cnt0)
  );

  lm_event_queue #(.WIDTH(8), .DEPTH(4), .DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .err_valid(ev[1]), .err_data(ed[1]),
    .dat_valid(dv[1]), .dat_data(dd[1]),
    .act_valid(av[1]), .act_data(ad[1]),
    .err_ready(er[1]), .dat_ready(dr[1]), .act_ready(ar[1]),
    .rd_data(rd[1]), .fifo_empty(emp[1]), .count(cnt1)
  );

  lm_event_queue #(.WIDTH(8), .DEPTH(8), .DWELL(100)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]),
    .err_valid(ev[2]), .err_data(ed[2]),
    .dat_valid(dv[2]), .dat_data(dd[2]),
    .act_valid(av[2]), .act_data(ad[2]),
    .err_ready(er[2]), .dat_ready(dr[2]), .act_ready(ar[2]),
    .rd_data(rd[2]), .fifo_empty(emp[2]), .count(cnt2)
  );

  // Model state: queue contents as a shifting list, and how many cycles the
  // current head has already been visible.
  logic [7:0] mq [NI][8];
  int         msz [NI];
  int         shown [NI];
  bit         ge [NI];
  bit         gd [NI];
  bit         ga [NI];
  bit         gp [NI];
  int         rst_hold [NI];
  bit         done [NI];
  int         n_cmp = 0;
  int         n_fail = 0;

  function automatic int dep_of(input int k);
    case (k)
      0: return 8;
      1: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int dwl_of(input int k);
    case (k)
      0: return 4;
      1: return 1;
      default: return 100;
    endcase
  endfunction

  task automatic cmp(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d t=%0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Expected outputs for the current cycle, plus the grant/pop decisions the
  // next rising edge will act on.
  task automatic checkOutput(input int k);
    bit         space;
    logic [7:0] exp_rd;
    gp[k] = rst_n[k] && (msz[k] > 0) && (shown[k] == dwl_of(k) - 1);
    space = rst_n[k] && ((msz[k] < dep_of(k)) || gp[k]);
    ge[k] = space && ev[k];
    gd[k] = space && dv[k] && !ev[k];
    ga[k] = space && av[k] && !ev[k] && !dv[k];
    exp_rd = (msz[k] > 0) ? mq[k][0] : 8'h00;
    cmp("rd_data", k, rd[k], exp_rd);
    cmp("fifo_empty", k, emp[k], msz[k] == 0);
    cmp("count", k, cnt_w[k], msz[k]);
    cmp("err_ready", k, er[k], ge[k]);
    cmp("dat_ready", k, dr[k], gd[k]);
    cmp("act_ready", k, ar[k], ga[k]);
  endtask

  task automatic updateModel(input int k);
    if (!rst_n[k]) begin
      msz[k] = 0;
      shown[k] = 0;
    end else begin
      if (msz[k] > 0) shown[k]++;
      if (gp[k]) begin
        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
        msz[k]--;
        shown[k] = 0;
      end
      if (ge[k] || gd[k] || ga[k]) begin
        mq[k][msz[k]] = ge[k] ? ed[k] : (gd[k] ? dd[k] : ad[k]);
        msz[k]++;
      end
    end
  endtask

  // Offers are held until granted; a granted or idle source may pick a new
  // random pattern. Occasional asynchronous resets discard the queue.
  task automatic applyStimulus(input int k, input int dens, input int cyc);
    if (rst_hold[k] > 0) begin
      rst_hold[k]--;
      if (rst_hold[k] == 0) rst_n[k] = 1'b1;
    end else if (cyc > 40 && $urandom_range(0, 499) == 0) begin
      rst_n[k] = 1'b0;
      rst_hold[k] = int'($urandom_range(1, 3));
      msz[k] = 0;
      shown[k] = 0;
    end
    if (ge[k] || !ev[k]) begin
      ev[k] = int'($urandom_range(0, 99)) < dens;
      ed[k] = 8'($urandom);
    end
    if (gd[k] || !dv[k]) begin
      dv[k] = int'($urandom_range(0, 99)) < dens;
      dd[k] = 8'($urandom);
    end
    if (ga[k] || !av[k]) begin
      av[k] = int'($urandom_range(0, 99)) < dens;
      ad[k] = 8'($urandom);
    end
  endtask

  task automatic runInstance(input int k);
    int         dens;
    int         ph;
    logic [7:0] lit [14];
    lit = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02,
            8'h02, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00};
    rst_n[k] = 1'b0;
    ev[k] = 1'b0; dv[k] = 1'b0; av[k] = 1'b0;
    ed[k] = 8'h00; dd[k] = 8'h00; ad[k] = 8'h00;
    msz[k] = 0; shown[k] = 0; rst_hold[k] = 0;
    ge[k] = 1'b0; gd[k] = 1'b0; ga[k] = 1'b0; gp[k] = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      checkOutput(k);
      // Hand-derived priority scenario on the DWELL=4 instance.
      if (k == 0 && cyc >= 3 && cyc <= 16) begin
        cmp("lit_rd", k, rd[0], lit[cyc-3]);
        cmp("lit_empty", k, emp[0], (cyc == 3 || cyc == 16));
        if (cyc == 6) cmp("lit_count", k, cnt_w[0], 3);
      end
      @(posedge clk);
      updateModel(k);
      #1;
      if (cyc == 2) begin
        rst_n[k] = 1'b1;
        if (k == 0) begin
          ev[k] = 1'b1; ed[k] = 8'h01;
          dv[k] = 1'b1; dd[k] = 8'h02;
          av[k] = 1'b1; ad[k] = 8'h03;
        end
      end else if (cyc > 2) begin
        if (k == 0 && cyc < 17) begin
          dens = 0;
        end else begin
          ph = cyc % 600;
          dens = (ph < 250) ? 50 : ((ph < 400) ? 15 : 0);
        end
        applyStimulus(k, dens, cyc);
      end
    end
    done[k] = 1'b1;
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_run
    initial runInstance(g);
  end

  initial begin
    int guard;
    guard = 0;
    while (!(done[0] && done[1] && done[2]) && guard < NCYC + 1000) begin
      @(posedge clk);
      guard++;
    end
    if (!(done[0] && done[1] && done[2])) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL timeout: got unfinished runs, expected all done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lm_event_queue.md
LM_EVENT_QUEUE -- requirements
Module: lm_event_queue

Interface
REQ-001 Parameter WIDTH, default WIDTH_LEDS (8): width of one LED pattern entry.
REQ-002 Parameter DEPTH, default 8, power of two >= 2: number of queue entries.
REQ-003 Parameter DWELL, default 25_000_000: clock cycles each entry is presented before it is popped; legal range 1..2^32-1.
REQ-004 clk  input  1  clock; all state SHALL update on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 err_valid / err_data  input  1 / WIDTH  error pattern offer.
REQ-007 dat_valid / dat_data  input  1 / WIDTH  data pattern offer.
REQ-008 act_valid / act_data  input  1 / WIDTH  actualization pattern offer.
REQ-009 err_ready / dat_ready / act_ready  output  1 each  offer accepted this cycle.
REQ-010 rd_data  output  WIDTH  head entry, for the LED decoder.
REQ-011 fifo_empty  output  1  high when queue holds no entries.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 Transfer on a source SHALL occur when its valid and ready are both high in the same cycle.
REQ-014 At most one push per cycle; fixed priority err > dat > act; only the granted source's ready SHALL be high, and only when a push is possible.
REQ-015 Push is possible when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-016 Ready SHALL depend only on registered state and the valid inputs; there is no path from data inputs to ready.
REQ-017 A pushed entry SHALL be visible on rd_data/fifo_empty the cycle after acceptance, if the queue was empty.
REQ-018 Pacing FSM states: IDLE (queue empty) and SHOW (head presented).
REQ-019 IDLE -> SHOW when count becomes nonzero; the dwell counter loads 0 on entry to SHOW.
REQ-020 In SHOW the counter SHALL increment each cycle; when it reaches DWELL-1, pop the head in that cycle and reset the counter to 0.
REQ-021 After a pop, SHOW -> IDLE if the queue becomes empty; otherwise stay in SHOW, so the next entry gets a full DWELL.
REQ-022 With DWELL=1, each entry SHALL be presented for exactly one cycle.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-024 A push into an empty queue during IDLE SHALL NOT be popped in the same cycle.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 rd_data SHALL be 0 whenever fifo_empty is high.
REQ-027 Non-granted sources SHALL hold their offer; nothing is dropped.

Reset
REQ-028 On rst_n low, the block SHALL immediately set: pointers 0, count 0, FSM IDLE, dwell counter 0.
REQ-029 During and immediately after reset, outputs SHALL be fifo_empty=1, rd_data=0, all readies 0.
REQ-030 Reset asserted mid-SHOW SHALL discard all entries, and the in-progress dwell SHALL NOT resume.

Structure
REQ-031 WIDTH_LEDS, the default DEPTH and DWELL, and the FSM state encodings SHALL live in the shared LM parameter file.
REQ-032 Storage SHALL be a sub-module lm_fifo_mem (DEPTH x WIDTH register array, one write port, asynchronous read).
REQ-033 Arbitration, pointers and pacing FSM SHALL be in lm_event_queue.

Verification
REQ-034 Priority: DWELL=4; err, dat and act valid together with patterns 0x01/0x02/0x03 -> grants in order err, dat, act; rd_data shows 0x01 for 4 cycles, then 0x02, then 0x03; fifo_empty rises after 12 cycles of display.
REQ-035 Full: DEPTH=8, DWELL=100; push 8 entries -> count=8, readies 0; 9th offer held until the first pop, then accepted in the pop cycle with count staying 8.
REQ-036 DWELL=1 stream: push 0xA5 every cycle for 20 cycles -> each value on rd_data for exactly one cycle, order preserved, count <= 2.
REQ-037 Reset mid-operation: assert rst_n low after 3 entries, 2 cycles into SHOW -> fifo_empty=1, rd_data=0, count=0 immediately; a new push after release gets a full DWELL.
REQ-038 Wrap: DEPTH=4, push/pop 10 entries 0x10..0x19 -> output sequence identical to input, pointers wrap twice.
